// File: rtl/piradspi_cmd_csr.sv
// piradspi_cmd_csr: SPI controller CSR block with a profile table, command FIFO and completion tracking.
// Define PIRADSPI_CMD_CSR_IRQ_EN to build the IRQ_EN/IRQ_STAT registers and a live irq output.
module piradspi_cmd_csr #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 8,
    parameter int NUM_PROFILES  = 8,
    parameter int NUM_DEVICES   = 8,
    parameter int CMD_DEPTH     = 4,
    localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       reg_wren,
    input  logic [REG_ADDR_BITS-1:0]   reg_wreg_no,
    input  logic [DATA_WIDTH-1:0]      reg_wdata,
    input  logic [DATA_WIDTH/8-1:0]    reg_wstrb,
    input  logic [REG_ADDR_BITS-1:0]   reg_rreg_no,
    output logic [DATA_WIDTH-1:0]      reg_rreg_data,
    output logic                       cmd_tvalid,
    input  logic                       cmd_tready,
    output logic [66+DEV_W-1:0]        cmd_tdata,
    input  logic                       done_valid,
    input  logic                       done_error,
    output logic                       engine_enable,
    output logic                       irq
);
    localparam int DW  = DATA_WIDTH;
    localparam int RAW = REG_ADDR_BITS;
    localparam int PW  = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;
    localparam int AW  = $clog2(CMD_DEPTH);
    localparam int OW  = AW + 2;
    localparam int EW  = 66 + DEV_W;

    localparam logic [RAW-1:0] A_MAGIC = RAW'('h00);
    localparam logic [RAW-1:0] A_VER   = RAW'('h01);
    localparam logic [RAW-1:0] A_CTRL  = RAW'('h02);
    localparam logic [RAW-1:0] A_DEV   = RAW'('h03);
    localparam logic [RAW-1:0] A_PSEL  = RAW'('h04);
    localparam logic [RAW-1:0] A_ID    = RAW'('h05);
    localparam logic [RAW-1:0] A_LVL   = RAW'('h06);
    localparam logic [RAW-1:0] A_DONE  = RAW'('h07);
    localparam logic [RAW-1:0] A_TRIG  = RAW'('h0F);
    localparam logic [RAW-1:0] A_PROF  = RAW'('h10);
    localparam logic [RAW-1:0] NPROF   = RAW'(NUM_PROFILES);
    localparam logic [DW-1:0]  NDEV    = DW'(NUM_DEVICES);
    localparam logic [DW-1:0]  NPSEL   = DW'(NUM_PROFILES);
    localparam logic [AW:0]    FULL_LVL = (AW+1)'(CMD_DEPTH);

    logic              enable, error, autoinc, overflow;
    logic [DEV_W-1:0]  device_sel;
    logic [PW-1:0]     profile_sel;
    logic [15:0]       cmd_id;
    logic [31:0]       done_count;
    logic [OW-1:0]     outstanding;

    logic [1:0]  p_mode [NUM_PROFILES];
    logic [7:0]  p_div  [NUM_PROFILES];
    logic [7:0]  p_wait [NUM_PROFILES];
    logic [7:0]  p_c2s  [NUM_PROFILES];
    logic [7:0]  p_s2c  [NUM_PROFILES];
    logic [15:0] p_len  [NUM_PROFILES];

    logic [EW-1:0] fifo [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;

    logic [DW-1:0]  wmask, dev_m, psel_m;
    logic           wr_ctrl, wr_dev, wr_psel, wr_id, trig, prof_wr;
    logic [RAW-1:0] pw_off, pr_off;
    logic           pw_hit, pr_hit;
    logic [PW-1:0]  pw_idx, pr_idx;
    logic           full, empty, pop, push, drop, err_set, busy;
    logic [EW-1:0]  entry;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old);
        return (old & ~wmask) | (reg_wdata & wmask);
    endfunction

    function automatic logic [7:0] m8(input logic [7:0] old);
        return reg_wstrb[0] ? reg_wdata[7:0] : old;
    endfunction

    function automatic logic [15:0] m16(input logic [15:0] old);
        return {reg_wstrb[1] ? reg_wdata[15:8] : old[15:8], m8(old[7:0])};
    endfunction

    assign full          = level == FULL_LVL;
    assign empty         = level == '0;
    assign cmd_tvalid    = enable && !empty;
    assign cmd_tdata     = fifo[rd_ptr];
    assign engine_enable = enable;
    assign pop           = cmd_tvalid && cmd_tready;
    // A full FIFO still accepts a trigger when the head leaves in the same cycle.
    assign push          = trig && (!full || pop);
    assign drop          = trig && full && !pop;

    // Expand byte enables into a bit mask.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DW / 8; i++) wmask[i*8 +: 8] = {8{reg_wstrb[i]}};
    end

    // Decode register writes, profile windows and the snapshot entry.
    always_comb begin
        wr_ctrl = reg_wren && reg_wreg_no == A_CTRL;
        wr_dev  = reg_wren && reg_wreg_no == A_DEV;
        wr_psel = reg_wren && reg_wreg_no == A_PSEL;
        wr_id   = reg_wren && reg_wreg_no == A_ID;
        trig    = reg_wren && reg_wreg_no == A_TRIG;
        pw_off  = reg_wreg_no - A_PROF;
        pr_off  = reg_rreg_no - A_PROF;
        pw_hit  = reg_wreg_no >= A_PROF && (pw_off >> 3) < NPROF;
        pr_hit  = reg_rreg_no >= A_PROF && (pr_off >> 3) < NPROF;
        pw_idx  = pw_off[PW+2:3];
        pr_idx  = pr_off[PW+2:3];
        prof_wr = reg_wren && pw_hit;
        dev_m   = merge(DW'(device_sel));
        psel_m  = merge(DW'(profile_sel));
        err_set = done_valid && (done_error || outstanding == '0);
        busy    = !empty || outstanding != '0;
        entry   = {p_mode[profile_sel], cmd_id, device_sel, p_div[profile_sel], p_wait[profile_sel],
                   p_c2s[profile_sel], p_s2c[profile_sel], p_len[profile_sel]};
    end

    // Control/status registers, selectors, command ID and completion counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            enable      <= 1'b0;
            autoinc     <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
            device_sel  <= '0;
            profile_sel <= '0;
            cmd_id      <= '0;
            done_count  <= '0;
            outstanding <= '0;
        end else begin
            if (wr_ctrl && reg_wstrb[0]) begin
                enable  <= reg_wdata[0];
                autoinc <= reg_wdata[3];
            end
            error    <= (error && !(wr_ctrl && reg_wstrb[0] && reg_wdata[1])) || err_set;
            overflow <= (overflow && !(wr_ctrl && reg_wstrb[0] && reg_wdata[4])) || drop;
            if (wr_dev && dev_m < NDEV) device_sel <= DEV_W'(dev_m);
            if (wr_psel && psel_m < NPSEL) profile_sel <= PW'(psel_m);
            if (wr_id) cmd_id <= m16(cmd_id);
            else if (push && autoinc) cmd_id <= cmd_id + 16'd1;
            if (done_valid) done_count <= done_count + 32'd1;
            if (pop && !done_valid) outstanding <= outstanding + 1'b1;
            else if (done_valid && !pop && outstanding != '0) outstanding <= outstanding - 1'b1;
        end
    end

    // Timing profile table with byte-enable writes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                p_mode[i] <= 2'b00;
                p_div[i]  <= 8'hFF;
                p_wait[i] <= 8'hFF;
                p_c2s[i]  <= 8'hFF;
                p_s2c[i]  <= 8'hFF;
                p_len[i]  <= 16'd8;
            end
        end else if (prof_wr) begin
            case (pw_off[2:0])
                3'd0:    p_mode[pw_idx] <= reg_wstrb[0] ? reg_wdata[1:0] : p_mode[pw_idx];
                3'd1:    p_div[pw_idx]  <= m8(p_div[pw_idx]);
                3'd2:    p_wait[pw_idx] <= m8(p_wait[pw_idx]);
                3'd3:    p_c2s[pw_idx]  <= m8(p_c2s[pw_idx]);
                3'd4:    p_s2c[pw_idx]  <= m8(p_s2c[pw_idx]);
                3'd5:    p_len[pw_idx]  <= m16(p_len[pw_idx]);
                default: ;
            endcase
        end
    end

    // Command FIFO: entries are full snapshots, so later profile edits never reach queued commands.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < CMD_DEPTH; i++) fifo[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= entry;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

`ifdef PIRADSPI_CMD_CSR_IRQ_EN
    localparam logic [RAW-1:0] A_IEN = RAW'('h08);
    localparam logic [RAW-1:0] A_IST = RAW'('h09);
    localparam logic [AW:0]    ONE_LVL = (AW+1)'(1);

    logic [2:0] irq_en, irq_stat, irq_en_nx, irq_stat_nx;
    logic       irq_q, empty_evt;

    // Next IRQ enable/status; irq registers off the next status so it rises one cycle after the event.
    always_comb begin
        empty_evt   = pop && !push && level == ONE_LVL;
        irq_en_nx   = (reg_wren && reg_wreg_no == A_IEN && reg_wstrb[0]) ? reg_wdata[2:0] : irq_en;
        irq_stat_nx = (irq_stat & ~((reg_wren && reg_wreg_no == A_IST && reg_wstrb[0]) ? reg_wdata[2:0] : 3'b000))
                    | {empty_evt, err_set, done_valid};
    end

    // IRQ enable, sticky status and registered interrupt line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_en   <= '0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en   <= irq_en_nx;
            irq_stat <= irq_stat_nx;
            irq_q    <= |(irq_en_nx & irq_stat_nx);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Combinational register read mux.
    always_comb begin
        reg_rreg_data = '0;
        case (reg_rreg_no)
            A_MAGIC: reg_rreg_data = DW'(32'h9170_0591);
            A_VER:   reg_rreg_data = DW'(32'h0000_0200);
            A_CTRL:  reg_rreg_data = DW'({overflow, autoinc, busy, error, enable});
            A_DEV:   reg_rreg_data = DW'(device_sel);
            A_PSEL:  reg_rreg_data = DW'(profile_sel);
            A_ID:    reg_rreg_data = DW'(cmd_id);
            A_LVL:   reg_rreg_data = DW'(level);
            A_DONE:  reg_rreg_data = DW'(done_count);
            A_TRIG:  reg_rreg_data = DW'({overflow, !full});
`ifdef PIRADSPI_CMD_CSR_IRQ_EN
            A_IEN:   reg_rreg_data = DW'(irq_en);
            A_IST:   reg_rreg_data = DW'(irq_stat);
`endif
            default: begin
                if (pr_hit) begin
                    case (pr_off[2:0])
                        3'd0:    reg_rreg_data = DW'(p_mode[pr_idx]);
                        3'd1:    reg_rreg_data = DW'(p_div[pr_idx]);
                        3'd2:    reg_rreg_data = DW'(p_wait[pr_idx]);
                        3'd3:    reg_rreg_data = DW'(p_c2s[pr_idx]);
                        3'd4:    reg_rreg_data = DW'(p_s2c[pr_idx]);
                        3'd5:    reg_rreg_data = DW'(p_len[pr_idx]);
                        default: reg_rreg_data = '0;
                    endcase
                end
            end
        endcase
    end
endmodule

// File: doc/piradspi_cmd_csr.md
Name: piradspi_cmd_csr

Overview:
Second-generation SPI controller CSR block. It holds a table of NUM_PROFILES timing profiles and snapshots the selected profile, device and command ID into an internal command FIFO of depth CMD_DEPTH on each trigger write. It drains that FIFO to the SPI engine over a valid/ready stream, tracks outstanding and completed transfers from engine completion reports, and raises sticky overflow and error status. It sits between the AXI4-Lite register server (register-interface side) and the SPI engine.

Parameters:
DATA_WIDTH, 32, register data width (32 or 64)
REG_ADDR_BITS, 8, register index width
NUM_PROFILES, 8, profile count; power of two, 1..16
NUM_DEVICES, 8, chip-select count; DEV_W = max(1, clog2(NUM_DEVICES))
CMD_DEPTH, 4, command FIFO entries; power of two, at least 2

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
reg_wren  in  1  register write strobe, one cycle
reg_wreg_no  in  REG_ADDR_BITS  write register index
reg_wdata  in  DATA_WIDTH  write data
reg_wstrb  in  DATA_WIDTH/8  byte enables
reg_rreg_no  in  REG_ADDR_BITS  read register index
reg_rreg_data  out  DATA_WIDTH  read data, combinational from reg_rreg_no
cmd_tvalid  out  1  command stream valid
cmd_tready  in  1  command stream ready
cmd_tdata  out  66+DEV_W  packed command, MSB first: cpol, cpha, id[15:0], device[DEV_W-1:0], sclk_div[7:0], start_wait[7:0], csn_to_sclk[7:0], sclk_to_csn[7:0], xfer_len[15:0]
done_valid  in  1  one-cycle engine completion pulse
done_error  in  1  completion carried an error
engine_enable  out  1  CTRLSTAT.enable
irq  out  1  interrupt; see Optional Feature

Behaviour:
- Reset: all outputs 0; FIFO empty; counters 0; cmd_id 0; profile_sel and device_sel 0.
- Profile reset values: cpol/cpha 0, timing fields 0xFF, xfer_len 8.
- Register map (index):
  - 0x00 magic 0x91700591 (RO).
  - 0x01 version 0x00000200 (RO).
  - 0x02 CTRLSTAT: b0 enable RW; b1 error W1C; b2 busy RO; b3 autoinc RW; b4 overflow W1C.
  - 0x03 device_sel RW.
  - 0x04 profile_sel RW.
  - 0x05 cmd_id RW, 16 bits.
  - 0x06 FIFO level RO.
  - 0x07 done_count RO, 32 bits, wrapping.
  - 0x0F trigger: write pushes a command; read returns {overflow, fifo_not_full}.
  - Profiles at 0x10 + 8*p: +0 {cpol b1, cpha b0}, +1 sclk_div, +2 start_wait, +3 csn_to_sclk, +4 sclk_to_csn, +5 xfer_len.
  - Unmapped indices read 0; writes to them are ignored.
- All RW writes honour reg_wstrb per byte.
- Writes of device_sel >= NUM_DEVICES or profile_sel >= NUM_PROFILES are ignored; the register keeps its value.
- Trigger, FIFO not full: one cycle later the entry holds the profile, device and cmd_id values as they were in the trigger cycle. Later profile writes do not alter queued entries.
- Trigger with autoinc=1 increments cmd_id after the snapshot; 0xFFFF wraps to 0.
- Trigger, FIFO full with no pop in the same cycle: command dropped, overflow set, cmd_id unchanged.
- Push and pop in the same cycle while full: push accepted, level unchanged.
- cmd_tvalid = enable AND FIFO not empty. First command appears one cycle after the trigger write (registered FIFO, first-word-fall-through).
- Clearing enable while cmd_tvalid is high drops tvalid; the entry is kept. This deliberate AXIS exception is permitted on this link only.
- outstanding counter (clog2(CMD_DEPTH)+2 bits):
  - +1 on cmd handshake; -1 on done_valid; unchanged when both occur in the same cycle.
  - done_valid while outstanding=0: set error, counter stays 0.
- done_valid increments done_count; done_valid with done_error=1 also sets error.
- busy = FIFO not empty OR outstanding != 0.
- A W1C write and a set event in the same cycle leave the bit set (set wins).
- Reset asserted mid-operation clears everything at once, including queued entries; cmd_tvalid falls asynchronously.

Optional Feature:
- Macro PIRADSPI_CMD_CSR_IRQ_EN.
- Defined:
  - 0x08 IRQ_EN RW bits {b0 done, b1 error, b2 fifo_empty}.
  - 0x09 IRQ_STAT W1C, same bits. done is set on done_valid; error on any error set; fifo_empty on the FIFO transitioning from non-empty to empty.
  - irq = |(IRQ_EN & IRQ_STAT), registered, one-cycle latency.
- Undefined: irq tied 0; 0x08 and 0x09 read 0 and ignore writes.

Test Plan:
- Reset -> read 0x00=0x91700591, 0x01=0x200, 0x06=0; read profile 3 +1 = 0xFF and +5 = 8; cmd_tvalid=0.
- Set profile 2 {cpol=1, cpha=0, xfer_len=24}; profile_sel=2, device_sel=5, cmd_id=0x10, autoinc=1, enable=1; trigger with cmd_tready=1 -> cmd_tvalid one cycle later, tdata id=0x10, device=5, xfer_len=24; cmd_id reads 0x11.
- enable=0, CMD_DEPTH=4, five triggers -> level=4, overflow=1, cmd_id advanced by 4; set enable=1 -> four handshakes in order, busy stays 1 until 4 done_valid pulses arrive.
- After a trigger, overwrite profile 2 before the pop -> popped entry carries the old values.
- done_valid with outstanding=0 -> error=1; W1C bit1 in the same cycle as done_error -> error stays 1; W1C again -> 0.
- IRQ_EN build: IRQ_EN=b001; one transfer -> irq=1 one cycle after done_valid; W1C IRQ_STAT -> irq=0.
